seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_decode.sv | 27 ++
 rtl/seg_scan_mux.sv | 129 ++++++++++++
 tb/tb_seg_scan_mux.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the four-digit seven-segment scanner.
// Segment patterns are active-low, bit 6 = a ... bit 0 = g.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;

  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-decimal codes (10..15) render as a dark digit.
module seg_decode
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [6:0]         seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed four-digit seven-segment driver with a one-deep pending
// buffer swapped in at frame boundaries. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]  presc_q, presc_d;
  logic [1:0]     idx_q, idx_d;
  logic [15:0]    disp_digits_q, disp_digits_d;
  logic [3:0]     disp_dp_q, disp_dp_d;
  logic [15:0]    pend_digits_q, pend_digits_d;
  logic [3:0]     pend_dp_q, pend_dp_d;
  logic           pend_full_q, pend_full_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;

  logic           tick;
  logic           frame_wrap;
  logic           capture;
  logic [3:0]     sel_digit;
  logic [6:0]     dec_seg;
  logic [3:0]     lz_mask;

  assign tick       = (presc_q == PRESC_LAST);
  assign frame_wrap = tick && (idx_q == 2'd3);
  assign load_ready = ~pend_full_q;
  assign capture    = load_valid && ~pend_full_q;
  assign sel_digit  = disp_digits_q[{idx_q, 2'b00} +: DIGIT_W];

  seg_decode u_seg_decode (
    .bcd (sel_digit),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero.
  logic [3:0] digit_zero;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
    assign digit_zero[gi] = (disp_digits_q[gi*DIGIT_W +: DIGIT_W] == 4'd0);
  end
  assign lz_mask[3] = digit_zero[3];
  for (genvar gi = 1; gi < NUM_DIGITS - 1; gi++) begin : g_lz
    assign lz_mask[gi] = digit_zero[gi] && lz_mask[gi+1];
  end
  assign lz_mask[0] = 1'b0;
`else
  assign lz_mask = 4'b0000;
`endif

  always_comb begin
    presc_d       = tick ? '0 : presc_q + PW'(1);
    idx_d         = tick ? idx_q + 2'd1 : idx_q;
    disp_digits_d = disp_digits_q;
    disp_dp_d     = disp_dp_q;
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_full_d   = pend_full_q;

    // Capture is only possible while pending is empty, so it never
    // collides with a pending-to-display transfer on the same edge.
    if (frame_wrap && pend_full_q) begin
      disp_digits_d = pend_digits_q;
      disp_dp_d     = pend_dp_q;
      pend_full_d   = 1'b0;
    end
    if (capture) begin
      pend_digits_d = digits_in;
      pend_dp_d     = dp_in;
      pend_full_d   = 1'b1;
    end

    an_d  = ~(4'b0001 << idx_q);
    seg_d = lz_mask[idx_q] ? SEG_OFF : dec_seg;
    dp_d  = ~disp_dp_q[idx_q];
    if (blank) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= 2'd0;
      disp_digits_q <= 16'h0000;
      disp_dp_q     <= 4'b0000;
      pend_digits_q <= 16'h0000;
      pend_dp_q     <= 4'b0000;
      pend_full_q   <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      disp_digits_q <= disp_digits_d;
      disp_dp_q     <= disp_dp_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_full_q   <= pend_full_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux at REFRESH_DIV=4: per-cycle reference model plus
// directed literal checks on loads, frame swaps, blanking and reset.
module tb_seg_scan_mux;

  localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;
  int nk = 0;

  seg_scan_mux #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the frame follows from edges since reset.
  bit          m_valid = 1'b0;
  int          m_k = 0;
  int          m_disp [4];
  bit          m_disp_dp [4];
  int          m_pend [4];
  bit          m_pend_dp [4];
  bit          m_pend_full = 1'b0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_ready;

  function automatic bit leading_zero(input int i);
    if (!LZ || i == 0) return 1'b0;
    for (int j = i; j < 4; j++) if (m_disp[j] != 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1;
      m_k = 0;
      m_pend_full = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_disp[i] = 0;
        m_disp_dp[i] = 1'b0;
      end
      exp_an = 4'hF;
      exp_seg = 7'h7F;
      exp_dp = 1'b1;
    end else begin
      int  idx;
      bit  wrap;
      bit  cap;
      idx  = (m_k / DIV) % 4;
      wrap = (m_k % (4 * DIV)) == (4 * DIV - 1);
      cap  = load_valid && !m_pend_full;
      if (blank) begin
        exp_an = 4'hF;
        exp_seg = 7'h7F;
        exp_dp = 1'b1;
      end else begin
        exp_an = ~(4'(1) << idx);
        exp_seg = leading_zero(idx) ? 7'h7F : seg_of(m_disp[idx]);
        exp_dp = ~m_disp_dp[idx];
      end
      if (wrap && m_pend_full) begin
        for (int i = 0; i < 4; i++) begin
          m_disp[i] = m_pend[i];
          m_disp_dp[i] = m_pend_dp[i];
        end
        m_pend_full = 1'b0;
      end
      if (cap) begin
        for (int i = 0; i < 4; i++) begin
          m_pend[i] = int'(digits_in[i*4 +: 4]);
          m_pend_dp[i] = dp_in[i];
        end
        m_pend_full = 1'b1;
      end
      m_k++;
    end
    exp_ready = ~m_pend_full;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_an", int'(an), int'(exp_an));
      chk("model_seg", int'(seg), int'(exp_seg));
      chk("model_dp", int'(dp), int'(exp_dp));
      chk("model_ready", int'(load_ready), int'(exp_ready));
    end
  end

  task automatic step();
    @(negedge clk);
    nk++;
  endtask

  task automatic goto(input int t);
    while (nk < t) step();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", int'(an), 'hF);
    chk("rst_seg", int'(seg), 'h7F);
    chk("rst_dp", int'(dp), 1);
    chk("rst_ready", int'(load_ready), 1);

    // Release and load 1234 on the first live edge.
    rst_n = 1'b1;
    digits_in = 16'h1234;
    dp_in = 4'b0000;
    load_valid = 1'b1;
    nk = 0;
    step();
    chk("n1_an", int'(an), 'hE);
    chk("n1_seg_zero", int'(seg), 'b0000001);
    chk("n1_ready_low", int'(load_ready), 0);
    digits_in = 16'h5678;           // must be ignored, pending full
    step();
    load_valid = 1'b0;
    goto(15);
    chk("ready_before_wrap", int'(load_ready), 0);
    step();
    chk("ready_after_wrap", int'(load_ready), 1);
    goto(17);
    chk("f1_an0", int'(an), 'hE);
    chk("f1_seg0", int'(seg), 'b1001100);
    goto(21);
    chk("f1_an1", int'(an), 'hD);
    chk("f1_seg1", int'(seg), 'b0000110);
    goto(25);
    chk("f1_an2", int'(an), 'hB);
    chk("f1_seg2", int'(seg), 'b0010010);
    goto(29);
    chk("f1_an3", int'(an), 'h7);
    chk("f1_seg3", int'(seg), 'b1001111);

    // Load 00A5 with dp on digit 1.
    goto(32);
    digits_in = 16'h00A5;
    dp_in = 4'b0010;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    goto(49);
    chk("a5_seg0", int'(seg), 'b0100100);
    chk("a5_dp0", int'(dp), 1);
    goto(53);
    chk("a5_seg1_dark", int'(seg), 'b1111111);
    chk("a5_dp1", int'(dp), 0);
    goto(57);
    chk("a5_seg2", int'(seg), LZ ? 'b1111111 : 'b0000001);
    goto(61);
    chk("a5_an3", int'(an), 'h7);
    chk("a5_seg3", int'(seg), LZ ? 'b1111111 : 'b0000001);

    // Capture exactly on the frame-wrap edge (edge 63).
    goto(63);
    digits_in = 16'h9876;
    dp_in = 4'b0000;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("wrapcap_ready", int'(load_ready), 0);
    step();
    chk("wrapcap_old_seg0", int'(seg), 'b0100100);
    goto(80);
    chk("wrapcap_ready_back", int'(load_ready), 1);
    step();
    chk("wrapcap_new_seg0", int'(seg), 'b0100000);

    // Blank for 10 clocks mid-frame.
    goto(86);
    blank = 1'b1;
    step();
    chk("blank_an", int'(an), 'hF);
    chk("blank_seg", int'(seg), 'h7F);
    goto(96);
    blank = 1'b0;
    step();
    chk("unblank_an", int'(an), 'hE);
    chk("unblank_seg", int'(seg), 'b0100000);

    // Reset for one cycle with pending full.
    goto(100);
    digits_in = 16'h1111;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    goto(104);
    rst_n = 1'b0;
    step();
    chk("r2_an", int'(an), 'hF);
    chk("r2_seg", int'(seg), 'h7F);
    chk("r2_ready", int'(load_ready), 1);
    rst_n = 1'b1;
    nk = 0;
    step();
    chk("r2_restart_an", int'(an), 'hE);
    chk("r2_restart_seg", int'(seg), 'b0000001);
    goto(17);
    chk("r2_pending_lost", int'(seg), 'b0000001);
    chk("r2_an_after_wrap", int'(an), 'hE);
    goto(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
